// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants for the round-robin arbiter in front of the 16:1 single-bit mux.
// Holds requester count, select width, default hold limit and FSM encoding.
package rr_mux_arbiter_pkg;

    localparam int N            = 16;
    localparam int SEL_W        = 4;
    localparam int HOLD_MAX_DEF = 8;
    localparam int CNT_W        = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side bundle of the arbiter: requests and release in, grant and mux select out.
// The arbiter uses the slave view; the requester side uses the master view.
interface rr_mux_arbiter_if;
    import rr_mux_arbiter_pkg::*;

    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output busy,
        output timeout
    );

endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping N-1 -> 0.
// Rotates req down by ptr, takes the lowest set bit, then adds ptr back (mod N).
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        off = '0;
        // Scan downward so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        any = |req;
        idx = ptr + off;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing a 16:1 mux: one owner at a time, hold-time bounded,
// one idle turnaround cycle after every release.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux_arbiter_if.slave  bus
);

    logic [0:0]       state_q,   state_d;
    logic [N-1:0]     grant_q,   grant_d;
    logic [SEL_W-1:0] sel_q,     sel_d;
    logic             busy_q,    busy_d;
    logic             timeout_q, timeout_d;
    logic [SEL_W-1:0] ptr_q,     ptr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             rel_owner;
    logic             rel_hold;

    rr_pick u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // done or a dropped owner request releases without a timeout indication.
    assign rel_owner = bus.done | ~bus.req[sel_q];
    assign rel_hold  = (cnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BUSY;
                    grant_d = onehot(pick_idx);
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (rel_owner || rel_hold) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = sel_q + SEL_W'(1);
                    cnt_d     = '0;
                    timeout_d = rel_hold & ~rel_owner;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus random traffic, checked every cycle
// against a behavioural model of the arbitration rules.
module tb_rr_mux_arbiter;

    localparam int HOLD = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Behavioural model state
    bit   m_busy;
    bit   m_to;
    int   m_sel;
    int   m_ptr;
    int   m_cnt;

    rr_mux_arbiter_if bus ();

    rr_mux_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the arbitration rules, using the inputs present at that edge.
    task automatic model_edge();
        bit ab;
        bit c;
        m_to = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_sel = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 16; k++) begin
                int i;
                i = (m_ptr + k) % 16;
                if (bus.req[i]) begin
                    m_busy = 1'b1; m_sel = i; m_cnt = 0;
                    break;
                end
            end
        end else begin
            ab = bus.done || !bus.req[m_sel];
            c  = (m_cnt == HOLD - 1);
            if (ab || c) begin
                m_busy = 1'b0;
                m_ptr  = (m_sel + 1) % 16;
                m_cnt  = 0;
                m_to   = c && !ab;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_grant;
        logic        inv_ok;
        exp_grant = m_busy ? (32'd1 << m_sel) : 32'd0;
        chk("grant",   32'(bus.grant),   exp_grant);
        chk("sel",     32'(bus.sel),     32'(m_sel));
        chk("busy",    32'(bus.busy),    32'(m_busy));
        chk("timeout", 32'(bus.timeout), 32'(m_to));
        inv_ok = ($countones(bus.grant) <= 1) && (bus.busy == (bus.grant != '0)) &&
                 (!bus.busy || bus.grant[bus.sel]);
        chk("invariant", 32'(inv_ok), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int run;
        total = 0; bad = 0;
        m_busy = 0; m_to = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
        rst = 1'b1; bus.req = 16'hFFFF; bus.done = 1'b0;

        // Reset with all requests asserted, then first grant goes to index 0
        do_reset();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_sel",   32'(bus.sel),   32'd0);
        step();
        chk("first_grant", 32'(bus.grant), 32'h0001);
        bus.done = 1'b1; step(); bus.done = 1'b0;

        // Single requester 5 with a done pulse on its third grant cycle
        bus.req = 16'h0000; do_reset();
        bus.req = 16'h0020;
        step();
        chk("single_sel", 32'(bus.sel), 32'd5);
        step(); step();
        bus.done = 1'b1; step(); bus.done = 1'b0;
        chk("single_rel", 32'(bus.busy), 32'd0);
        step();
        chk("single_regrant", 32'(bus.grant), 32'h0020);

        // Rotation between 0 and 15
        bus.req = 16'h0000; do_reset();
        bus.req = 16'h8001;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rot_owner", 32'(bus.sel), (k % 2 == 0) ? 32'd0 : 32'd15);
            step();
            bus.done = 1'b1; step(); bus.done = 1'b0;
            chk("rot_gap", 32'(bus.grant), 32'd0);
        end

        // Hold limit: exactly HOLD grant cycles then timeout with the gap
        bus.req = 16'h0000; do_reset();
        bus.req = 16'h0008;
        step();
        run = 0;
        for (int i = 0; i < 20 && bus.busy; i++) begin
            run++;
            step();
        end
        chk("hold_len", 32'(run), 32'(HOLD));
        chk("hold_timeout", 32'(bus.timeout), 32'd1);
        step();
        chk("hold_regrant", 32'(bus.grant), 32'h0008);
        chk("hold_to_clear", 32'(bus.timeout), 32'd0);

        // Owner 7 drops its request on grant cycle 2
        bus.req = 16'h0000; do_reset();
        bus.req = 16'h0080;
        step(); step();
        bus.req = 16'h0000;
        step();
        chk("drop_busy", 32'(bus.busy), 32'd0);
        chk("drop_to", 32'(bus.timeout), 32'd0);

        // done coincides with the last hold cycle: one release, no timeout
        do_reset();
        bus.req = 16'h0010;
        step();
        repeat (HOLD - 1) step();
        bus.done = 1'b1; step(); bus.done = 1'b0;
        chk("prec_busy", 32'(bus.busy), 32'd0);
        chk("prec_to", 32'(bus.timeout), 32'd0);

        // Reset while owner 9 is active; arbitration then restarts from 0
        bus.req = 16'h0000; do_reset();
        bus.req = 16'h0200;
        step(); step();
        chk("mid_sel9", 32'(bus.sel), 32'd9);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_grant", 32'(bus.grant), 32'd0);
        chk("mid_sel", 32'(bus.sel), 32'd0);
        bus.req = 16'h0201;
        step();
        chk("mid_regrant", 32'(bus.grant), 32'h0001);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0)
                bus.req = 16'($urandom & $urandom);
            bus.done = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; bus.done = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
